forward_hazard_ctrl: RTL
========================

FORWARD_HAZARD_CTRL -- requirements
Module: forward_hazard_ctrl

Interface
REQ-001 Parameter: REG_ADDR_WIDTH, default 5, register-index width.
REQ-002 Port: clk  input  1  pipeline clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: valid_ID  input  1  ID stage holds a real instruction.
REQ-005 Port: rs1_ID, rs2_ID  input  REG_ADDR_WIDTH each  source registers of the ID instruction.
REQ-006 Port: rd_ID  input  REG_ADDR_WIDTH  destination register of the ID instruction.
REQ-007 Port: reg_write_ID, mem_read_ID  input  1 each  ID instruction writes rd / is a load.
REQ-008 Port: flush_EX  input  1  taken branch/jump resolved in EX; kill the younger ID instruction.
REQ-009 Port: mem_stall  input  1  data memory busy; freeze the whole pipeline.
REQ-010 Port: forward_detect_EX_rs1, forward_detect_EX_rs2  output  3 each  one-hot forwarding select for the EX operand muxes.
REQ-011 Port: stall_IF, stall_ID  output  1 each  hold PC / hold IF-ID register.
REQ-012 Port: bubble_EX  output  1  load a NOP into the ID/EX register.
REQ-013 Port: ctrl_state  output  2  current FSM state, for debug.

Function
REQ-014 The block SHALL keep a record {valid, rd, reg_write, mem_read, rs1, rs2} for each of EX, MEM and WB.
REQ-015 On an advance cycle (state not MEM_WAIT, mem_stall=0): WB<=MEM, MEM<=EX, and EX<=ID record, or an invalid record when a bubble is inserted.
REQ-016 Forward select encoding: bit FORWARD_NONE=0, FORWARD_COLLISION_IN_MEM=1, FORWARD_COLLISION_IN_WB=2; exactly one bit is set at all times.
REQ-017 forward_detect_EX_rsN SHALL be combinational from registered records only, with no path from ID-stage inputs.
REQ-018 MEM bit is set when MEM.valid, MEM.reg_write, MEM.rd!=0 and MEM.rd==EX.rsN.
REQ-019 WB bit is set when the MEM bit is not set and the same conditions hold for the WB record.
REQ-020 Otherwise the NONE bit is set; register x0 is never forwarded.
REQ-021 Load-use hazard = valid_ID, EX.valid, EX.mem_read, EX.rd!=0 and (EX.rd==rs1_ID or EX.rd==rs2_ID).
REQ-022 FSM states: RUN=0, LOAD_STALL=1, MEM_WAIT=2; value 3 is illegal and SHALL recover to RUN.
REQ-023 RUN: a load-use hazard without flush_EX asserts stall_IF=stall_ID=bubble_EX=1 in the same cycle; next state is LOAD_STALL.
REQ-024 LOAD_STALL: all outputs deasserted; next state is RUN. Exactly one bubble is inserted per load-use; the consumer later forwards from WB.
REQ-025 flush_EX=1 (not MEM_WAIT) SHALL assert bubble_EX and insert an invalid EX record; stall_IF and stall_ID stay 0.
REQ-026 flush_EX overrides a simultaneous load-use hazard; next state is RUN.
REQ-027 mem_stall=1 in any state SHALL force stall_IF=stall_ID=1 and bubble_EX=0, hold all records, and move to MEM_WAIT.
REQ-028 MEM_WAIT holds while mem_stall=1; on mem_stall=0 it advances normally, re-evaluating load-use in that cycle as in RUN.
REQ-029 Priority: mem_stall > flush_EX > load-use.
REQ-030 An invalid ID instruction SHALL never cause a stall.

Reset
REQ-031 While rst=1: all records invalid with fields 0, state RUN, stall_IF=stall_ID=bubble_EX=0, both forward selects 3'b001.
REQ-032 Reset asserted mid-stall SHALL abort the stall immediately, without waiting for a clock edge.

Structure
REQ-033 Forward-bit indices, FSM state encodings and the NOP record SHALL live in the shared pipeline defines/package, which is also used by the EX forwarding muxes.
REQ-034 One sub-module, stage_record_reg, SHALL implement a single holdable stage record; it is instantiated three times.

Verification
REQ-035 add x5 then add x6,x5,x1 back-to-back -> next cycle forward_detect_EX_rs1=3'b010.
REQ-036 add x5, unrelated instruction, sub x7,x2,x5 -> forward_detect_EX_rs2=3'b100 when sub is in EX.
REQ-037 Both MEM and WB write x5, EX reads x5 -> 3'b010 (MEM wins); writes to x0 -> 3'b001.
REQ-038 lw x5 in EX, add x6,x5,x5 in ID -> one cycle of stall_IF=stall_ID=bubble_EX=1, ctrl_state=1, then add in EX with both selects 3'b100.
REQ-039 Load-use plus flush_EX in the same cycle -> bubble_EX=1, stall_IF=stall_ID=0, ctrl_state stays 0.
REQ-040 mem_stall high for 3 cycles mid-load-use, then rst pulsed during MEM_WAIT -> records frozen for 3 cycles, and all outputs at reset values asynchronously.

Source files
------------

// File: rtl/forward_hazard_ctrl_pkg.sv
// Shared pipeline definitions: forward-select bit positions, control FSM encoding and NOP flags.
// Also imported by the EX-stage operand muxes that consume the one-hot forward selects.
package forward_hazard_ctrl_pkg;

    localparam int unsigned FWD_W                    = 3;
    localparam int unsigned FORWARD_NONE             = 0;
    localparam int unsigned FORWARD_COLLISION_IN_MEM = 1;
    localparam int unsigned FORWARD_COLLISION_IN_WB  = 2;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2
    } ctrl_state_e;

    typedef struct packed {
        logic valid;
        logic reg_write;
        logic mem_read;
    } stage_ctrl_t;

    // Control half of the NOP record; register fields of a NOP are all zero.
    localparam stage_ctrl_t NOP_CTRL = '{valid: 1'b0, reg_write: 1'b0, mem_read: 1'b0};

    function automatic logic [FWD_W-1:0] fwd_onehot(input logic hit_mem, input logic hit_wb);
        logic [FWD_W-1:0] sel;
        sel = '0;
        if (hit_mem) begin
            sel[FORWARD_COLLISION_IN_MEM] = 1'b1;
        end else if (hit_wb) begin
            sel[FORWARD_COLLISION_IN_WB] = 1'b1;
        end else begin
            sel[FORWARD_NONE] = 1'b1;
        end
        return sel;
    endfunction

endpackage

// File: rtl/forward_hazard_ctrl_if.sv
// ID-stage instruction info, pipeline control inputs and hazard/forwarding outputs.
interface forward_hazard_ctrl_if #(
    parameter int unsigned REG_ADDR_WIDTH = 5
);
    import forward_hazard_ctrl_pkg::*;

    logic                      valid_ID;
    logic [REG_ADDR_WIDTH-1:0] rs1_ID;
    logic [REG_ADDR_WIDTH-1:0] rs2_ID;
    logic [REG_ADDR_WIDTH-1:0] rd_ID;
    logic                      reg_write_ID;
    logic                      mem_read_ID;
    logic                      flush_EX;
    logic                      mem_stall;
    logic [FWD_W-1:0]          forward_detect_EX_rs1;
    logic [FWD_W-1:0]          forward_detect_EX_rs2;
    logic                      stall_IF;
    logic                      stall_ID;
    logic                      bubble_EX;
    logic [1:0]                ctrl_state;

    modport slave (
        input  valid_ID, rs1_ID, rs2_ID, rd_ID, reg_write_ID, mem_read_ID, flush_EX, mem_stall,
        output forward_detect_EX_rs1, forward_detect_EX_rs2, stall_IF, stall_ID, bubble_EX,
               ctrl_state
    );

    modport master (
        output valid_ID, rs1_ID, rs2_ID, rd_ID, reg_write_ID, mem_read_ID, flush_EX, mem_stall,
        input  forward_detect_EX_rs1, forward_detect_EX_rs2, stall_IF, stall_ID, bubble_EX,
               ctrl_state
    );

endinterface

// File: rtl/stage_record_reg.sv
// One pipeline-stage record register: loads d when enabled, otherwise holds.
module stage_record_reg #(
    parameter type rec_t = logic [7:0]
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  rec_t d,
    output rec_t q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/forward_hazard_ctrl.sv
// Tracks EX/MEM/WB destination records to drive operand forwarding selects and
// load-use / flush / memory-stall pipeline control.
module forward_hazard_ctrl
    import forward_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    forward_hazard_ctrl_if.slave hz
);

    typedef struct packed {
        stage_ctrl_t               ctrl;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic [REG_ADDR_WIDTH-1:0] rs1;
        logic [REG_ADDR_WIDTH-1:0] rs2;
    } stage_rec_t;

    localparam stage_rec_t NOP_REC = '{ctrl: NOP_CTRL, rd: '0, rs1: '0, rs2: '0};

    stage_rec_t  id_rec, ex_d, ex_q, mem_q, wb_q;
    ctrl_state_e state_q, state_d;
    logic        advance, load_use, stall, bubble;

    assign id_rec = '{ctrl: '{valid: hz.valid_ID, reg_write: hz.reg_write_ID,
                              mem_read: hz.mem_read_ID},
                      rd: hz.rd_ID, rs1: hz.rs1_ID, rs2: hz.rs2_ID};

    // Leaving MEM_WAIT is an ordinary advance cycle, so only mem_stall freezes records.
    assign advance = ~hz.mem_stall;
    assign ex_d    = bubble ? NOP_REC : id_rec;

    stage_record_reg #(.rec_t(stage_rec_t)) u_ex_rec (
        .clk(clk), .rst(rst), .en(advance), .d(ex_d),  .q(ex_q)
    );
    stage_record_reg #(.rec_t(stage_rec_t)) u_mem_rec (
        .clk(clk), .rst(rst), .en(advance), .d(ex_q),  .q(mem_q)
    );
    stage_record_reg #(.rec_t(stage_rec_t)) u_wb_rec (
        .clk(clk), .rst(rst), .en(advance), .d(mem_q), .q(wb_q)
    );

    function automatic logic writes_reg(input stage_rec_t r, input logic [REG_ADDR_WIDTH-1:0] rs);
        return r.ctrl.valid && r.ctrl.reg_write && (r.rd != '0) && (r.rd == rs);
    endfunction

    assign hz.forward_detect_EX_rs1 = fwd_onehot(writes_reg(mem_q, ex_q.rs1),
                                                 writes_reg(wb_q, ex_q.rs1));
    assign hz.forward_detect_EX_rs2 = fwd_onehot(writes_reg(mem_q, ex_q.rs2),
                                                 writes_reg(wb_q, ex_q.rs2));

    assign load_use = hz.valid_ID && ex_q.ctrl.valid && ex_q.ctrl.mem_read && (ex_q.rd != '0) &&
                      ((ex_q.rd == hz.rs1_ID) || (ex_q.rd == hz.rs2_ID));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        bubble  = 1'b0;
        if (hz.mem_stall) begin
            stall   = 1'b1;
            state_d = MEM_WAIT;
        end else begin
            case (state_q)
                RUN, MEM_WAIT: begin
                    state_d = RUN;
                    if (hz.flush_EX) begin
                        bubble = 1'b1;
                    end else if (load_use) begin
                        stall   = 1'b1;
                        bubble  = 1'b1;
                        state_d = LOAD_STALL;
                    end
                end
                LOAD_STALL: state_d = RUN;
                default:    state_d = RUN;
            endcase
        end
    end

    // Gate with rst so an in-progress stall drops immediately, not at the next edge.
    assign hz.stall_IF   = stall & ~rst;
    assign hz.stall_ID   = stall & ~rst;
    assign hz.bubble_EX  = bubble & ~rst;
    assign hz.ctrl_state = state_q;

endmodule
